// File: rtl/pbch_pkg.sv
// Shared PBCH constants for the post-FFT receive chain.
// Complex samples are packed as {I,Q}: the I component occupies the upper
// DATA_W bits of a 2*DATA_W word and Q the lower DATA_W bits.
package pbch_pkg;

   localparam int NUM_PBCH_RE = 432;
   localparam int PBCH_DATA_W = 16;
   localparam int PBCH_ADDR_W = 10;

   // Slot index of each component within a packed {I,Q} word, in units of DATA_W.
   localparam int IQ_I_SEL = 1;
   localparam int IQ_Q_SEL = 0;

   typedef struct packed {
      logic signed [PBCH_DATA_W-1:0] i;
      logic signed [PBCH_DATA_W-1:0] q;
   } pbch_iq_t;

endpackage

// File: rtl/cmac_conj.sv
// Pipelined complex multiply by the conjugate, y*conj(h), plus |h|^2.
// Stage 1 registers the six signed partial products, stage 2 forms the sums,
// rounds half-up, drops DATA_W-1 fractional bits and saturates to DATA_W.
// Ports:
//   clk, rst        clock, async active-high reset
//   in_valid        qualifies yr/yi/hr/hi
//   yr, yi, hr, hi  signed input components
//   out_valid       qualifies out_re/out_im/out_p (two cycles after in_valid)
//   out_re, out_im  signed Re/Im of y*conj(h), held while out_valid=0
//   out_p           unsigned |h|^2, clamped to 2^(DATA_W-1)-1, held while out_valid=0
module cmac_conj
   import pbch_pkg::*;
#(
   parameter int DATA_W = PBCH_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] yr,
   input  logic signed [DATA_W-1:0] yi,
   input  logic signed [DATA_W-1:0] hr,
   input  logic signed [DATA_W-1:0] hi,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] out_re,
   output logic signed [DATA_W-1:0] out_im,
   output logic        [DATA_W-1:0] out_p
);

   localparam int PW = 2 * DATA_W;
   localparam int SW = PW + 1;
   localparam logic signed [SW-1:0] HALF    = SW'(longint'(1) << (DATA_W - 2));
   localparam logic signed [SW-1:0] SAT_MAX = SW'((longint'(1) << (DATA_W - 1)) - 1);
   localparam logic signed [SW-1:0] SAT_MIN = SW'(-(longint'(1) << (DATA_W - 1)));

   logic                 s2_valid;
   logic signed [PW-1:0] p_yrhr, p_yihi, p_yihr, p_yrhi, p_hrhr, p_hihi;

   logic signed [SW-1:0] s_re, s_im, s_p;
   logic signed [SW-1:0] r_re, r_im, r_p;
   logic signed [DATA_W-1:0] re_sat, im_sat;
   logic        [DATA_W-1:0] p_sat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         p_yrhr   <= '0;
         p_yihi   <= '0;
         p_yihr   <= '0;
         p_yrhi   <= '0;
         p_hrhr   <= '0;
         p_hihi   <= '0;
      end else begin
         s2_valid <= in_valid;
         if (in_valid) begin
            p_yrhr <= yr * hr;
            p_yihi <= yi * hi;
            p_yihr <= yi * hr;
            p_yrhi <= yr * hi;
            p_hrhr <= hr * hr;
            p_hihi <= hi * hi;
         end
      end
   end

   // One extra bit of headroom keeps (-2^(W-1))^2 + (-2^(W-1))^2 from wrapping.
   always_comb begin
      s_re = SW'(p_yrhr) + SW'(p_yihi);
      s_im = SW'(p_yihr) - SW'(p_yrhi);
      s_p  = SW'(p_hrhr) + SW'(p_hihi);
      r_re = (s_re + HALF) >>> (DATA_W - 1);
      r_im = (s_im + HALF) >>> (DATA_W - 1);
      r_p  = (s_p  + HALF) >>> (DATA_W - 1);

      re_sat = DATA_W'(r_re);
      if (r_re > SAT_MAX)      re_sat = DATA_W'(SAT_MAX);
      else if (r_re < SAT_MIN) re_sat = DATA_W'(SAT_MIN);

      im_sat = DATA_W'(r_im);
      if (r_im > SAT_MAX)      im_sat = DATA_W'(SAT_MAX);
      else if (r_im < SAT_MIN) im_sat = DATA_W'(SAT_MIN);

      // |h|^2 is never negative, so only the upper clamp is needed.
      p_sat = DATA_W'(r_p);
      if (r_p > SAT_MAX) p_sat = DATA_W'(SAT_MAX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_p     <= '0;
      end else begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            out_re <= re_sat;
            out_im <= im_sat;
            out_p  <= p_sat;
         end
      end
   end

endmodule

// File: rtl/pbch_re_equalizer.sv
// PBCH resource-element equaliser. For each valid index pair it reads the
// received RE and the averaged channel estimate, outputs y*conj(h) with the
// |h|^2 weight, and tracks the per-SSB RE count with done/overrun flags.
// Ports:
//   clk, rst               clock, async active-high reset
//   start                  new SSB: clears RE counter and overrun flag
//   idx_fft, idx_ch        RE addresses, qualified by idx_valid
//   fft_raddr/fft_ren      FFT symbol buffer read port, fft_rdata one cycle later
//   ch_raddr/ch_ren        channel-average buffer read port, ch_rdata one cycle later
//   eq_i, eq_q, csi        equalised RE and |h|^2, qualified by eq_valid
//   re_idx                 RE index within the SSB travelling with the data
//   done                   pulse with the RE whose index is NUM_RE-1
//   err_overrun            sticky: an RE arrived after NUM_RE had been counted
module pbch_re_equalizer
   import pbch_pkg::*;
#(
   parameter int DATA_W = PBCH_DATA_W,
   parameter int ADDR_W = PBCH_ADDR_W,
   parameter int NUM_RE = NUM_PBCH_RE
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [ADDR_W-1:0]   idx_fft,
   input  logic [ADDR_W-1:0]   idx_ch,
   input  logic                idx_valid,
   output logic [ADDR_W-1:0]   fft_raddr,
   output logic                fft_ren,
   input  logic [2*DATA_W-1:0] fft_rdata,
   output logic [ADDR_W-1:0]   ch_raddr,
   output logic                ch_ren,
   input  logic [2*DATA_W-1:0] ch_rdata,
   output logic [DATA_W-1:0]   eq_i,
   output logic [DATA_W-1:0]   eq_q,
   output logic [DATA_W-1:0]   csi,
   output logic                eq_valid,
   output logic [8:0]          re_idx,
   output logic                done,
   output logic                err_overrun
);

   localparam logic [8:0] CNT_FULL = 9'(NUM_RE);
   localparam logic [8:0] LAST_IDX = 9'(NUM_RE - 1);

   logic [8:0] re_cnt;
   logic [8:0] idx_sel;
   logic [8:0] idx0, idx1, idx2;
   logic       v1, v2;

   logic signed [DATA_W-1:0] y_r, y_i, h_r, h_i;
   logic signed [DATA_W-1:0] eq_re, eq_im;

   // Overrun REs keep flowing but reuse the last legal index.
   always_comb begin
      idx_sel = re_cnt;
      if (start)                   idx_sel = '0;
      else if (re_cnt == CNT_FULL) idx_sel = LAST_IDX;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fft_raddr   <= '0;
         ch_raddr    <= '0;
         fft_ren     <= 1'b0;
         ch_ren      <= 1'b0;
         idx0        <= '0;
         idx1        <= '0;
         idx2        <= '0;
         v1          <= 1'b0;
         v2          <= 1'b0;
         re_idx      <= '0;
         done        <= 1'b0;
         re_cnt      <= '0;
         err_overrun <= 1'b0;
      end else begin
         fft_ren <= idx_valid;
         ch_ren  <= idx_valid;
         if (idx_valid) begin
            fft_raddr <= idx_fft;
            ch_raddr  <= idx_ch;
            idx0      <= idx_sel;
         end
         v1   <= fft_ren;
         idx1 <= idx0;
         v2   <= v1;
         idx2 <= idx1;
         if (v2) re_idx <= idx2;
         done <= v2 && (idx2 == LAST_IDX);

         // start does not flush the pipeline; only the counter restarts.
         if (start) begin
            re_cnt      <= idx_valid ? 9'd1 : 9'd0;
            err_overrun <= 1'b0;
         end else if (idx_valid) begin
            if (re_cnt == CNT_FULL) err_overrun <= 1'b1;
            else                    re_cnt      <= re_cnt + 9'd1;
         end
      end
   end

   // The RAM output register is the data-return stage; slice it directly.
   assign y_r = fft_rdata[IQ_I_SEL*DATA_W +: DATA_W];
   assign y_i = fft_rdata[IQ_Q_SEL*DATA_W +: DATA_W];
   assign h_r = ch_rdata[IQ_I_SEL*DATA_W +: DATA_W];
   assign h_i = ch_rdata[IQ_Q_SEL*DATA_W +: DATA_W];

   cmac_conj #(
      .DATA_W (DATA_W)
   ) u_cmac (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v1),
      .yr        (y_r),
      .yi        (y_i),
      .hr        (h_r),
      .hi        (h_i),
      .out_valid (eq_valid),
      .out_re    (eq_re),
      .out_im    (eq_im),
      .out_p     (csi)
   );

   assign eq_i = eq_re;
   assign eq_q = eq_im;

endmodule
